fb_write_arbiter: RTL
=====================

Name: fb_write_arbiter

Overview:
Shares the single frame-buffer write port among NUM_SM shader-multiprocessor render units.
- Each SM offers one completed 256-bit tile row-pair (two 16-pixel rows, 8-bit colour).
- The block grants requesters round-robin and splits each row-pair into two 128-bit beats.
- It computes the 15-bit frame-buffer word address and counts completed row-pairs to flag frame completion.
- It sits between the SM array and the frame-buffer write port (port A of the dual-port frame block memory; the VGA scan-out side reads port B).

Parameters:
- NUM_SM, 4, number of requesting render units (2..8).
- TILES_X, 40, tiles per line (640/16).
- TILES_Y, 30, tile rows per frame (480/16).
- FB_ADDR_W, 15, frame-buffer write address width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- i_req  in  NUM_SM  per-SM request; held with stable data until granted.
- i_tile_x  in  NUM_SM*6  per-SM tile column, packed, SM0 in LSBs.
- i_tile_y  in  NUM_SM*6  per-SM tile row.
- i_tile_row  in  NUM_SM*4  per-SM pixel row in tile; bit 0 ignored.
- i_color_data  in  NUM_SM*256  per-SM row-pair colour data.
- i_frame_clear  in  1  clears the row-pair counter and the completion flag.
- o_grant  out  NUM_SM  one-hot, combinational; data is captured at the clock edge ending the cycle it is high.
- o_fb_we  out  1  frame-buffer write enable (registered).
- o_fb_addr  out  FB_ADDR_W  write word address (registered).
- o_fb_data  out  128  write data (registered).
- o_frame_complete  out  1  sticky: all TILES_X*TILES_Y*8 row-pairs written.
- o_err  out  1  sticky: an out-of-range tile was granted.

Behaviour:
- Reset (asynchronous, any state, mid-burst included):
  - state=IDLE, RR pointer=0.
  - o_fb_we=0, o_fb_addr=0, o_fb_data=0.
  - counter=0, o_frame_complete=0, o_err=0.
  - o_grant=0 while reset_n is low.
  - A half-written row-pair is abandoned.
- States:
  - IDLE: outputs not valid.
  - BEAT0: low half on outputs.
  - BEAT1: high half on outputs.
- Grant window:
  - A grant may issue only in IDLE or BEAT1, when |i_req.
  - The winner is the first requesting index at or after the pointer, wrapping.
  - After a grant, pointer = (winner+1) mod NUM_SM.
- Capture at the granting edge:
  - Register the high 128 bits into a hold register.
  - Drive o_fb_we=1, o_fb_data=data[127:0], o_fb_addr={idx, row[3:1], 1'b0}, where idx = tile_y*TILES_X + tile_x (11 bits).
  - Next state BEAT0.
- BEAT0 -> BEAT1 unconditionally:
  - o_fb_we=1, o_fb_data=hold, address LSB set to 1.
  - Increment the row-pair counter.
- BEAT1:
  - On a new grant, go to BEAT0; back-to-back throughput is one row-pair per 2 cycles.
  - With no request, go to IDLE with o_fb_we=0.
- Latency: grant edge to first beat visible is 1 cycle; the second beat follows 1 cycle later.
- Out-of-range request (tile_x>=TILES_X or tile_y>=TILES_Y):
  - Still granted, so the requester is consumed.
  - No write occurs: o_fb_we=0, next state IDLE.
  - o_err is set.
- Counter (14 bits):
  - Reaching TILES_X*TILES_Y*8 (9600) sets o_frame_complete and holds the count; it does not wrap.
  - Further writes are still performed but not counted.
- i_frame_clear:
  - Counter=0 and o_frame_complete=0.
  - Clear wins over a simultaneous increment; that row-pair is not counted.
  - Clear does not affect o_err or an in-progress write.
- o_err clears only on reset.
- i_req dropping before grant is legal: the request is simply withdrawn.
- Data arithmetic:
  - idx = tile_y*40 + tile_x computed as (y<<5)+(y<<3)+x, 11-bit unsigned.
  - o_fb_addr = idx*16 + row[3:1]*2 + half.

Decomposition:
- Package fb_pkg:
  - TILES_X, TILES_Y, FB_ADDR_W, BEAT_W=128, ROWPAIRS_PER_FRAME.
  - State enum {IDLE, BEAT0, BEAT1}.
  - Tile-index function.
- One sub-module: rr_arbiter, which takes req, pointer and an enable, and returns the one-hot grant plus the next pointer.

Test Plan:
- Single request: SM1 req, x=3, y=2, row=5, data=D -> grant[1] for 1 cycle.
  - Next cycle: we=1, addr=1332, data=D[127:0].
  - Following cycle: addr=1333, data=D[255:128].
  - Then we=0.
- Contention: all 4 SMs req continuously, pointer=0 -> grant order 0,1,2,3,0 every 2 cycles; we stays high continuously.
- Out-of-range: SM2 req, x=40, y=0 -> grant[2], o_err=1, no we pulse.
  - A subsequent valid request still writes.
- Frame completion: 9600 valid row-pairs -> o_frame_complete rises on the 9600th second beat.
  - Pulse i_frame_clear in the same cycle as a completion -> count=0, flag=0.
- Reset mid-operation: assert reset_n low during BEAT0 -> we=0 immediately (asynchronous).
  - After release, state is IDLE, pointer is 0, and no second beat is issued.
- Withdrawn request: SM0 req for 1 cycle while in BEAT0, then drops -> no grant, and the state returns to IDLE after BEAT1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write arbiter.
// Frame geometry is 640x480 in 16x16 tiles; each write beat is half of a
// 256-bit row-pair (two 16-pixel rows of 8-bit colour).
package fb_pkg;

    localparam int unsigned TILES_X            = 40;
    localparam int unsigned TILES_Y            = 30;
    localparam int unsigned FB_ADDR_W          = 15;
    localparam int unsigned BEAT_W             = 128;
    localparam int unsigned ROWPAIR_W          = 2 * BEAT_W;
    localparam int unsigned TILE_COORD_W       = 6;
    localparam int unsigned TILE_ROW_W         = 4;
    localparam int unsigned TILE_IDX_W         = 11;
    localparam int unsigned CNT_W              = 14;
    localparam int unsigned ROWPAIRS_PER_FRAME = TILES_X * TILES_Y * 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } fb_state_e;

    // Request payload of the SM currently holding the grant.
    typedef struct packed {
        logic [TILE_COORD_W-1:0] tile_x;
        logic [TILE_COORD_W-1:0] tile_y;
        logic [TILE_ROW_W-1:0]   tile_row;
        logic [ROWPAIR_W-1:0]    data;
    } fb_req_t;

    // Linear tile index for a 40-tile-wide frame: y*40 + x as shift-add.
    function automatic logic [TILE_IDX_W-1:0] tile_index(
        input logic [TILE_COORD_W-1:0] tile_y,
        input logic [TILE_COORD_W-1:0] tile_x
    );
        logic [TILE_IDX_W-1:0] y_w;
        logic [TILE_IDX_W-1:0] x_w;
        y_w = TILE_IDX_W'(tile_y);
        x_w = TILE_IDX_W'(tile_x);
        return (y_w << 5) + (y_w << 3) + x_w;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Round-robin arbiter.
//   req      : request vector
//   ptr      : index with highest priority this cycle
//   en       : grant window open
//   grant    : one-hot grant (combinational)
//   next_ptr : winner + 1 modulo N, ptr when nothing is granted
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] next_ptr
);

    int unsigned cand;
    logic        found;

    // Scan from ptr upward with wrap; first requester wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (en && !found && req[PTR_W'(cand)]) begin
                found                = 1'b1;
                grant[PTR_W'(cand)]  = 1'b1;
                next_ptr             = PTR_W'((cand + 1) % N);
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write-port arbiter: grants NUM_SM render units round-robin,
// writes each granted row-pair as two 128-bit beats on consecutive cycles
// and counts completed row-pairs to flag frame completion.
//   clk, reset_n      : clock, asynchronous active-low reset
//   i_req             : per-SM request, held with stable data until granted
//   i_tile_x/_y       : per-SM tile coordinates (6 bits each, SM0 in LSBs)
//   i_tile_row        : per-SM pixel row inside tile (bit 0 ignored)
//   i_color_data      : per-SM 256-bit row-pair
//   i_frame_clear     : clears row-pair counter and completion flag
//   o_grant           : one-hot combinational grant
//   o_fb_we/addr/data : registered frame-buffer write port
//   o_frame_complete  : sticky, full frame of row-pairs written
//   o_err             : sticky, out-of-range tile granted
module fb_write_arbiter #(
    parameter int unsigned NUM_SM    = 4,
    parameter int unsigned TILES_X   = fb_pkg::TILES_X,
    parameter int unsigned TILES_Y   = fb_pkg::TILES_Y,
    parameter int unsigned FB_ADDR_W = fb_pkg::FB_ADDR_W
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic [NUM_SM-1:0]                        i_req,
    input  logic [NUM_SM*fb_pkg::TILE_COORD_W-1:0]   i_tile_x,
    input  logic [NUM_SM*fb_pkg::TILE_COORD_W-1:0]   i_tile_y,
    input  logic [NUM_SM*fb_pkg::TILE_ROW_W-1:0]     i_tile_row,
    input  logic [NUM_SM*fb_pkg::ROWPAIR_W-1:0]      i_color_data,
    input  logic                                     i_frame_clear,
    output logic [NUM_SM-1:0]                        o_grant,
    output logic                                     o_fb_we,
    output logic [FB_ADDR_W-1:0]                     o_fb_addr,
    output logic [fb_pkg::BEAT_W-1:0]                o_fb_data,
    output logic                                     o_frame_complete,
    output logic                                     o_err
);

    import fb_pkg::*;

    localparam int unsigned PTR_W        = $clog2(NUM_SM);
    localparam int unsigned FRAME_TARGET = TILES_X * TILES_Y * 8;

    fb_state_e             state_q;
    fb_state_e             state_d;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      ptr_d;
    logic [PTR_W-1:0]      ptr_nxt;
    logic [NUM_SM-1:0]     grant_c;
    logic                  arb_en;
    fb_req_t               sel;
    logic [TILE_IDX_W-1:0] sel_idx;
    logic                  granted;
    logic                  in_range;
    logic                  good_grant;
    logic [BEAT_W-1:0]     hold_q;
    logic [BEAT_W-1:0]     hold_d;
    logic                  fb_we_d;
    logic [FB_ADDR_W-1:0]  fb_addr_d;
    logic [BEAT_W-1:0]     fb_data_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic                  done_d;
    logic                  err_d;
    logic                  unused_row_lsb;

    // Grants only when the port is free next cycle; forced off during reset.
    assign arb_en = reset_n && ((state_q == IDLE) || (state_q == BEAT1));

    rr_arbiter #(
        .N     (NUM_SM),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req      (i_req),
        .ptr      (ptr_q),
        .en       (arb_en),
        .grant    (grant_c),
        .next_ptr (ptr_nxt)
    );

    assign o_grant = grant_c;

    // One-hot mux of the winner's payload.
    always_comb begin
        sel = '0;
        for (int unsigned j = 0; j < NUM_SM; j++) begin
            if (grant_c[j]) begin
                sel.tile_x   = i_tile_x[j*TILE_COORD_W +: TILE_COORD_W];
                sel.tile_y   = i_tile_y[j*TILE_COORD_W +: TILE_COORD_W];
                sel.tile_row = i_tile_row[j*TILE_ROW_W +: TILE_ROW_W];
                sel.data     = i_color_data[j*ROWPAIR_W +: ROWPAIR_W];
            end
        end
    end

    // Each row-pair holds two pixel rows, so the row LSB carries no address.
    assign unused_row_lsb = sel.tile_row[0];

    if (TILES_X == 40) begin : g_idx_shift
        assign sel_idx = tile_index(sel.tile_y, sel.tile_x);
    end else begin : g_idx_mul
        assign sel_idx = TILE_IDX_W'(32'(sel.tile_y) * TILES_X + 32'(sel.tile_x));
    end

    assign granted    = |grant_c;
    assign in_range   = (32'(sel.tile_x) < TILES_X) && (32'(sel.tile_y) < TILES_Y);
    assign good_grant = granted && in_range;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an out-of-range grant consumes the requester but
    // leaves the port idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, BEAT1: state_d = good_grant ? BEAT0 : IDLE;
            BEAT0:       state_d = BEAT1;
            default:     state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer, hold and counter.
    always_comb begin
        fb_we_d   = 1'b0;
        fb_addr_d = o_fb_addr;
        fb_data_d = o_fb_data;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        err_d     = o_err;

        if (granted) begin
            ptr_d = ptr_nxt;
            if (!in_range) begin
                err_d = 1'b1;
            end
        end

        if (good_grant) begin
            fb_we_d   = 1'b1;
            fb_data_d = sel.data[BEAT_W-1:0];
            hold_d    = sel.data[ROWPAIR_W-1:BEAT_W];
            fb_addr_d = FB_ADDR_W'({sel_idx, sel.tile_row[3:1], 1'b0});
        end

        // Second beat; the row-pair is counted as it goes out.
        if (state_q == BEAT0) begin
            fb_we_d   = 1'b1;
            fb_data_d = hold_q;
            fb_addr_d = {o_fb_addr[FB_ADDR_W-1:1], 1'b1};
            if (cnt_q != CNT_W'(FRAME_TARGET)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Clear beats a simultaneous increment.
        if (i_frame_clear) begin
            cnt_d = '0;
        end

        // Count saturates at the target, so the flag stays set until cleared.
        done_d = (cnt_d == CNT_W'(FRAME_TARGET));
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q            <= '0;
            hold_q           <= '0;
            cnt_q            <= '0;
            o_fb_we          <= 1'b0;
            o_fb_addr        <= '0;
            o_fb_data        <= '0;
            o_frame_complete <= 1'b0;
            o_err            <= 1'b0;
        end else begin
            ptr_q            <= ptr_d;
            hold_q           <= hold_d;
            cnt_q            <= cnt_d;
            o_fb_we          <= fb_we_d;
            o_fb_addr        <= fb_addr_d;
            o_fb_data        <= fb_data_d;
            o_frame_complete <= done_d;
            o_err            <= err_d;
        end
    end

endmodule
